// File: rtl/delivery_pkg.sv
// Shared types and default parameters for the
// multi-channel delivery tracker.
package delivery_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASED
  } delivery_state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/delivery_tracker_if.sv
// Event and status bundle between the dock
// event sources and the delivery tracker.
interface delivery_tracker_if
  import delivery_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
);

  logic [NUM_CH-1:0] shipment_open;
  logic [NUM_CH-1:0] customs_cleared;
  logic [NUM_CH-1:0] transit_ready;
  logic [NUM_CH-1:0] arrived_on_truck;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] shipment_released;
  logic [NUM_CH-1:0] delivery_confirmed;
  logic [NUM_CH-1:0] delivery_expired;
  logic [CNT_W-1:0]  confirmed_count;

  modport master (
    output shipment_open,
    output customs_cleared,
    output transit_ready,
    output arrived_on_truck,
    input  busy,
    input  shipment_released,
    input  delivery_confirmed,
    input  delivery_expired,
    input  confirmed_count
  );

  modport slave (
    input  shipment_open,
    input  customs_cleared,
    input  transit_ready,
    input  arrived_on_truck,
    output busy,
    output shipment_released,
    output delivery_confirmed,
    output delivery_expired,
    output confirmed_count
  );

endinterface

// File: rtl/delivery_channel.sv
// One shipment channel: open -> hold -> released
// -> delivered, with a per-shipment timeout.
module delivery_channel
  import delivery_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic open_i,
  input  logic cust_i,
  input  logic tran_i,
  input  logic arr_i,
  output logic busy_o,
  output logic rel_o,
  output logic conf_o,
  output logic exp_o,
  output logic conf_next_o
);

  localparam int CW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t TMO_LAST =
    (TIMEOUT_CYC > 0) ? cnt_t'(TIMEOUT_CYC - 1) : '0;

  delivery_state_e state_q, state_d;
  logic cust_q, cust_d;
  logic tran_q, tran_d;
  cnt_t cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic rel_q, rel_d;
  logic conf_q, conf_d;
  logic exp_q, exp_d;
  logic tmo;

  always_comb begin
    state_d = state_q;
    cust_d  = cust_q;
    tran_d  = tran_q;
    cnt_d   = cnt_q;
    conf_d  = 1'b0;
    exp_d   = 1'b0;
    tmo     = (TIMEOUT_CYC != 0) && (cnt_q == TMO_LAST);
    unique case (state_q)
      IDLE: begin
        if (open_i) begin
          state_d = HOLD;
          cust_d  = 1'b0;
          tran_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        cnt_d  = cnt_q + cnt_t'(1);
        cust_d = cust_q | cust_i;
        tran_d = tran_q | tran_i;
        // expiry wins over a release landing this cycle
        if (tmo) begin
          state_d = IDLE;
          exp_d   = 1'b1;
        end else if (cust_d && tran_d) begin
          state_d = RELEASED;
        end
      end
      RELEASED: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (arr_i) begin
          state_d = IDLE;
          conf_d  = 1'b1;
        end else if (tmo) begin
          state_d = IDLE;
          exp_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    rel_d  = (state_d == RELEASED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cust_q  <= 1'b0;
      tran_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      rel_q   <= 1'b0;
      conf_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cust_q  <= cust_d;
      tran_q  <= tran_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      rel_q   <= rel_d;
      conf_q  <= conf_d;
      exp_q   <= exp_d;
    end
  end

  assign busy_o      = busy_q;
  assign rel_o       = rel_q;
  assign conf_o      = conf_q;
  assign exp_o       = exp_q;
  assign conf_next_o = conf_d;

endmodule

// File: rtl/delivery_tracker.sv
// NUM_CH independent delivery channels plus a
// saturating count of confirmed deliveries.
module delivery_tracker
  import delivery_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic clk,
  input logic rst_n,
  delivery_tracker_if.slave bus
);

  localparam int PW = $clog2(NUM_CH + 1);
  localparam int SW = CNT_W + PW + 1;

  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] rel;
  logic [NUM_CH-1:0] conf;
  logic [NUM_CH-1:0] expd;
  logic [NUM_CH-1:0] conf_now;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    delivery_channel #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .open_i     (bus.shipment_open[i]),
      .cust_i     (bus.customs_cleared[i]),
      .tran_i     (bus.transit_ready[i]),
      .arr_i      (bus.arrived_on_truck[i]),
      .busy_o     (busy[i]),
      .rel_o      (rel[i]),
      .conf_o     (conf[i]),
      .exp_o      (expd[i]),
      .conf_next_o(conf_now[i])
    );
  end

  logic [PW-1:0]    pop;
  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] count_q, count_d;

  // count tracks the confirm pulses landing at this edge
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + PW'(conf_now[i]);
    end
    sum = SW'(count_q) + SW'(pop);
    if (sum > SW'({CNT_W{1'b1}})) begin
      count_d = '1;
    end else begin
      count_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.busy               = busy;
  assign bus.shipment_released  = rel;
  assign bus.delivery_confirmed = conf;
  assign bus.delivery_expired   = expd;
  assign bus.confirmed_count    = count_q;

endmodule

// File: doc/delivery_tracker.md
# delivery_tracker

Multi-channel, sequential successor to the single-shipment delivery gate. Each of `NUM_CH` independent channels tracks one shipment from open to release (customs cleared and transit ready, in either order, across any cycles) to delivery (truck arrival after release), with a per-shipment timeout. The block also keeps a saturating total of confirmed deliveries. It sits between the per-dock event sources and the dispatch/reporting logic.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent shipment channels (≥1).
- `TIMEOUT_CYC`, 255: maximum cycles a channel may stay open; 0 disables the timeout.
- `CNT_W`, 16: width of `confirmed_count`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `shipment_open`  in  NUM_CH  per-channel pulse that opens tracking.
- `customs_cleared`  in  NUM_CH  per-channel customs event.
- `transit_ready`  in  NUM_CH  per-channel transit event.
- `arrived_on_truck`  in  NUM_CH  per-channel arrival event.
- `busy`  out  NUM_CH  channel is not IDLE.
- `shipment_released`  out  NUM_CH  level, high while the channel is in RELEASED.
- `delivery_confirmed`  out  NUM_CH  one-cycle pulse on delivery.
- `delivery_expired`  out  NUM_CH  one-cycle pulse on timeout.
- `confirmed_count`  out  CNT_W  saturating total of confirmations.

## Operation
- Per-channel FSM with states IDLE, HOLD and RELEASED. Reset puts every channel in IDLE.
- On reset, every output is 0: `busy`, `shipment_released`, `delivery_confirmed`, `delivery_expired` and `confirmed_count`.
- **IDLE:**
  - `shipment_open` moves the channel to HOLD.
  - Entering HOLD clears the sticky flags and the timeout counter.
  - All other inputs are ignored in IDLE.
- **HOLD:**
  - `customs_cleared` and `transit_ready` each set a sticky flag.
  - When both flags are set (from earlier cycles, this cycle, or a mix), the channel moves to RELEASED.
  - `arrived_on_truck` is ignored in HOLD; it is not remembered.
- **RELEASED:**
  - `arrived_on_truck` moves the channel to IDLE and pulses `delivery_confirmed`.
  - Customs and transit inputs are ignored.
- `shipment_open` is ignored while the channel is busy.
- **Timeout counter:**
  - Width is $clog2(TIMEOUT_CYC+1).
  - It increments every cycle the channel is in HOLD or RELEASED.
  - When it equals TIMEOUT_CYC-1, the channel moves to IDLE and pulses `delivery_expired`.
- **Precedence:**
  - In HOLD, a timeout beats a release completing in the same cycle.
  - In RELEASED, arrival beats a timeout in the same cycle (confirm, no expire).
- **Count:** `confirmed_count` adds the popcount of this cycle's confirmations. It saturates at all-ones and never wraps.
- **Reset mid-operation:** all channels drop to IDLE immediately. Pulses and the count clear asynchronously. No pending flag survives reset.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Let `shipment_open` be sampled at edge 0. Then `busy`=1 from cycle 1, and events are sampled from edge 1.
- If the second of customs/transit is sampled at edge k, `shipment_released`=1 in cycle k+1. The earliest arrival that counts is sampled at edge k+1.
- If arrival is sampled at edge m in RELEASED, then in cycle m+1:
  - `delivery_confirmed`=1 for exactly one cycle;
  - `busy`=0 and `shipment_released`=0;
  - `confirmed_count` has incremented.
- The channel can reopen with `shipment_open` sampled at edge m+1.
- Timeout: `busy` stays high for exactly TIMEOUT_CYC cycles. `delivery_expired` pulses in cycle TIMEOUT_CYC+1 after the open edge.
- Channels are fully independent, and simultaneous events on different channels are all honoured.

## Structure
- Package `delivery_pkg`: `delivery_state_e` enum {IDLE, HOLD, RELEASED} and the default parameter constants.
- Sub-module `delivery_channel`: one FSM, its sticky flags, timeout counter and pulse registers. It is instantiated NUM_CH times in a generate loop.
- Top level `delivery_tracker`: generate loop, popcount, saturating `confirmed_count` register.

## Test plan
- **Basic flow:** open ch0, customs at +2, transit at +5, arrival at +8.
  - `shipment_released` high from cycle 6.
  - `delivery_confirmed`[0] pulses in cycle 9.
  - `confirmed_count`=1.
- **Early arrival:** arrival in HOLD, then customs+transit together, then no further arrival.
  - Channel stays RELEASED.
  - No confirm occurs.
- **Timeout (TIMEOUT_CYC=10):** open only.
  - `busy` high for exactly 10 cycles.
  - `delivery_expired` pulses in cycle 11.
- **Timeout ties (TIMEOUT_CYC=10):**
  - Release completes on the expiry cycle → expired, not released.
  - Arrival on the expiry cycle in RELEASED → confirmed, not expired.
- **Multi-channel and saturation:** 4 channels confirm in the same cycle → count +4. With CNT_W=3, starting at 6, +4 → 7.
- **Reset mid-operation:** assert `rst_n`=0 while channels are in HOLD/RELEASED → all outputs 0 immediately; after release, a reopened channel needs both flags again.
